// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared types, constants and the baud divider helper for the
//             UART blocks (RX front end now, TX side later).
//  Contents : rx_state_t   - receiver FSM state encoding
//             DATA_BITS    - payload bits per frame
//             SYNC_STAGES  - depth of the rxd input synchroniser
//             calc_div()   - sys_clk cycles per oversample tick
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_t;

  localparam int DATA_BITS   = 8;
  localparam int SYNC_STAGES = 2;

  // Rounded-to-nearest divider, never below 1 so the tick always runs.
  function automatic int calc_div(input int clk_hz, input int baud, input int oversample);
    int tick_hz;
    int div;
    tick_hz = baud * oversample;
    div     = (clk_hz + tick_hz / 2) / tick_hz;
    return (div < 1) ? 1 : div;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
//  Module   : uart_baud_tick
//  Purpose  : Free-running oversample tick generator. Emits a one-cycle tick
//             every DIV sys_clk cycles; clr restarts the phase so the next
//             tick lands DIV cycles after clr is released.
//  Ports    : sys_clk  in  clock
//             reset_n  in  asynchronous active-low reset
//             clr      in  phase clear (suppresses the tick while high)
//             tick     out one-cycle tick pulse
//  Revision : 1.0 - initial release
// ============================================================================
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic sys_clk,
  input  logic reset_n,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST) && !clr;

endmodule
`default_nettype wire

// File: rtl/uart_rx_frontend.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_frontend
//  Purpose  : UART receiver, 8 data bits LSB first, 1 stop bit. Presents each
//             byte on a ready/accept holding register and flags framing
//             errors, overruns and (optionally) even-parity errors.
//  Config   : `define UART_RX_PARITY_EN adds one even-parity bit after the
//             data bits (11-bit frame). Without it parity_err is tied 0.
//  Ports    : sys_clk         in  clock
//             reset_n         in  asynchronous active-low reset
//             rxd             in  serial line, idle high, asynchronous
//             rx_data         out received byte, valid while rx_data_ready
//             rx_data_ready   out byte held, waiting for accept
//             rx_data_accept  in  one-cycle consumer strobe
//             frame_err       out one-cycle pulse, stop bit sampled 0
//             overrun         out one-cycle pulse, byte dropped (holding full)
//             parity_err      out one-cycle pulse, parity mismatch
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_frontend
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 sys_clk,
  input  logic                 reset_n,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_data_ready,
  input  logic                 rx_data_accept,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 parity_err
);

  localparam int              DIV       = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int              OS_W      = $clog2(OVERSAMPLE);
  localparam int              BIT_W     = $clog2(DATA_BITS);
  localparam logic [OS_W-1:0] HALF_LAST = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] FULL_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
  localparam rx_state_t AFTER_DATA = PARITY;
`else
  localparam rx_state_t AFTER_DATA = STOP;
`endif

  // --------------------------------------------------------------------------
  // Input synchroniser (reset to idle-high so reset never looks like a start)
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxd_s;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
    end
  end

  assign rxd_s = sync_q[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Oversample tick, phase re-aligned to the detected start edge
  // --------------------------------------------------------------------------
  rx_state_t state;
  logic      tick;
  logic      start_det;

  assign start_det = (state == IDLE) && !rxd_s;

  uart_baud_tick #(
    .DIV (DIV)
  ) u_tick (
    .sys_clk (sys_clk),
    .reset_n (reset_n),
    .clr     (start_det),
    .tick    (tick)
  );

  // --------------------------------------------------------------------------
  // Receive FSM
  // --------------------------------------------------------------------------
  logic [OS_W-1:0]      os_cnt;
  logic [BIT_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 deliver;   // byte complete, hand to holding register
  logic                 mid_start; // half-bit point of the start bit
  logic                 mid_bit;   // centre of every following bit

  assign mid_start = tick && (os_cnt == HALF_LAST);
  assign mid_bit   = tick && (os_cnt == FULL_LAST);

`ifdef UART_RX_PARITY_EN
  logic par_bad;
`endif

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      os_cnt    <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      deliver   <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      deliver   <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      // Counts ticks within the current bit; reset at every sample point.
      if (tick) begin
        os_cnt <= os_cnt + OS_W'(1);
      end

      case (state)
        IDLE: begin
          if (!rxd_s) begin
            state  <= START;
            os_cnt <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
          end
        end

        START: begin
          if (mid_start) begin
            os_cnt  <= '0;
            bit_idx <= '0;
            // A line already back high at mid-start was a glitch.
            state   <= rxd_s ? IDLE : DATA;
          end
        end

        DATA: begin
          if (mid_bit) begin
            os_cnt  <= '0;
            shreg   <= {rxd_s, shreg[DATA_BITS-1:1]};
            bit_idx <= bit_idx + BIT_W'(1);
            if (bit_idx == LAST_BIT) begin
              state <= AFTER_DATA;
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (mid_bit) begin
            os_cnt <= '0;
            // Even parity: data ones plus the parity bit must be even.
            if (rxd_s != (^shreg)) begin
              par_bad    <= 1'b1;
              parity_err <= 1'b1;
            end
            state <= STOP;
          end
        end
`endif

        STOP: begin
          if (mid_bit) begin
            os_cnt <= '0;
            if (rxd_s) begin
`ifdef UART_RX_PARITY_EN
              deliver <= !par_bad;
`else
              deliver <= 1'b1;
`endif
              state   <= IDLE;
            end else begin
              // A frame already flagged for parity reports only that error.
`ifdef UART_RX_PARITY_EN
              frame_err <= !par_bad;
`else
              frame_err <= 1'b1;
`endif
              state     <= BREAK;
            end
          end
        end

        BREAK: begin
          if (rxd_s) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Holding register and ready/accept handshake. An accept in the delivery
  // cycle frees the slot, so the new byte loads instead of overrunning.
  // --------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_data       <= '0;
      rx_data_ready <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (deliver) begin
        if (!rx_data_ready || rx_data_accept) begin
          rx_data       <= shreg;
          rx_data_ready <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_data_accept && rx_data_ready) begin
        rx_data_ready <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
